// File: rtl/bus_arbiter_ctrl_if.sv
// Bus bundle between the two masters, the slave-side done strobe and the arbiter.
// master: request/valid/address/done drivers; slave: the arbiter's view.
interface bus_arbiter_ctrl_if;
  logic       m1_request;
  logic       m2_request;
  logic       m1_master_valid;
  logic       m2_master_valid;
  logic       m1_tx_address;
  logic       m2_tx_address;
  logic       trans_done;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] master_grant;
  logic [2:0] slave_grant;
  logic       addr_error;
  logic       bus_timeout;

  modport master (
    output m1_request, m2_request,
    output m1_master_valid, m2_master_valid,
    output m1_tx_address, m2_tx_address,
    output trans_done,
    input  m1_grant, m2_grant, master_grant,
    input  slave_grant, addr_error, bus_timeout
  );

  modport slave (
    input  m1_request, m2_request,
    input  m1_master_valid, m2_master_valid,
    input  m1_tx_address, m2_tx_address,
    input  trans_done,
    output m1_grant, m2_grant, master_grant,
    output slave_grant, addr_error, bus_timeout
  );
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// Round-robin arbiter for two serial-bus masters with slave-ID decode.
// Ports: clk, rstn (async active-low), bus (requests in, grants/pulses out).
module bus_arbiter_ctrl #(
  parameter int SLAVE_ID_W = 2,
  parameter int TIMEOUT    = 255
) (
  input logic              clk,
  input logic              rstn,
  bus_arbiter_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(SLAVE_ID_W + 1);

  typedef enum logic [1:0] {
    IDLE, ADDR, CONN, REL
  } state_t;

  state_t st_q, st_d;
  // owner / last: 0 = m1, 1 = m2
  logic own_q, own_d;
  logic last_q, last_d;
  logic [SLAVE_ID_W-1:0] id_q, id_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] to_q, to_d;
  logic m1g_q, m1g_d;
  logic m2g_q, m2g_d;
  logic [2:0] sg_q, sg_d;
  logic err_q, err_d;
  logic tmo_q, tmo_d;

  logic req, vld, adr, rel, hit;
  logic [SLAVE_ID_W-1:0] id_nx;
  logic [CW-1:0] to_inc;

  always_comb begin
    req = own_q ? bus.m2_request : bus.m1_request;
    vld = own_q ? bus.m2_master_valid
                : bus.m1_master_valid;
    adr = own_q ? bus.m2_tx_address
                : bus.m1_tx_address;
    id_nx = {id_q[SLAVE_ID_W-2:0], adr};
    // saturating stall counter
    to_inc = (to_q == CW'(TIMEOUT))
           ? to_q : to_q + 1'b1;
    hit = (to_inc == CW'(TIMEOUT));
  end

  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    last_d = last_q;
    id_d   = id_q;
    bit_d  = bit_q;
    to_d   = to_q;
    m1g_d  = m1g_q;
    m2g_d  = m2g_q;
    sg_d   = sg_q;
    err_d  = 1'b0;
    tmo_d  = 1'b0;
    rel    = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.m1_request || bus.m2_request) begin
          st_d = ADDR;
          // tie goes to whoever was not served last
          if (bus.m1_request && bus.m2_request)
            own_d = ~last_q;
          else
            own_d = bus.m2_request;
          m1g_d = ~own_d;
          m2g_d = own_d;
          id_d  = '0;
          bit_d = '0;
          to_d  = '0;
        end
      end
      ADDR: begin
        if (!req) begin
          rel = 1'b1;
        end else if (vld) begin
          id_d  = id_nx;
          bit_d = bit_q + 1'b1;
          to_d  = '0;
          if (bit_q == BW'(SLAVE_ID_W - 1)) begin
            if (id_nx == '0) begin
              rel   = 1'b1;
              err_d = 1'b1;
            end else begin
              st_d = CONN;
              sg_d = {id_nx, 1'b1};
            end
          end
        end else begin
          to_d = to_inc;
          if (hit) begin
            rel   = 1'b1;
            tmo_d = 1'b1;
          end
        end
      end
      CONN: begin
        if (bus.trans_done || !req) begin
          rel = 1'b1;
        end else begin
          to_d = to_inc;
          if (hit) begin
            rel   = 1'b1;
            tmo_d = 1'b1;
          end
        end
      end
      REL: begin
        st_d   = IDLE;
        last_d = own_q;
        id_d   = '0;
        bit_d  = '0;
        to_d   = '0;
      end
      default: st_d = IDLE;
    endcase
    if (rel) begin
      st_d  = REL;
      m1g_d = 1'b0;
      m2g_d = 1'b0;
      sg_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      own_q  <= 1'b0;
      last_q <= 1'b1;
      id_q   <= '0;
      bit_q  <= '0;
      to_q   <= '0;
      m1g_q  <= 1'b0;
      m2g_q  <= 1'b0;
      sg_q   <= '0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      last_q <= last_d;
      id_q   <= id_d;
      bit_q  <= bit_d;
      to_q   <= to_d;
      m1g_q  <= m1g_d;
      m2g_q  <= m2g_d;
      sg_q   <= sg_d;
      err_q  <= err_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.m1_grant     = m1g_q;
  assign bus.m2_grant     = m2g_q;
  assign bus.master_grant = {m2g_q, m1g_q};
  assign bus.slave_grant  = sg_q;
  assign bus.addr_error   = err_q;
  assign bus.bus_timeout  = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Bench for bus_arbiter_ctrl: directed scenarios then random traffic,
// every cycle compared with a transaction-level reference model.
module tb_bus_arbiter_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bus_arbiter_ctrl_if bus ();

  bus_arbiter_ctrl #(
    .SLAVE_ID_W(2),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // reference model: owner 0=none,1=m1,2=m2
  int own, last, rel_own, sid, wcnt;
  bit releasing, conn, e_err, e_to;
  int bits[$];

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    own = 0;
    last = 2;
    rel_own = 0;
    releasing = 0;
    conn = 0;
    sid = 0;
    wcnt = 0;
    e_err = 0;
    e_to = 0;
    bits.delete();
  endtask

  task automatic mdl_release();
    rel_own = own;
    own = 0;
    conn = 0;
    releasing = 1;
    bits.delete();
  endtask

  task automatic mdl_step(input bit r1, r2, v1, v2,
                          input bit a1, a2, d);
    bit r, v, a;
    e_err = 0;
    e_to = 0;
    if (releasing) begin
      releasing = 0;
      last = rel_own;
    end else if (own == 0) begin
      if (r1 && r2) own = (last == 1) ? 2 : 1;
      else if (r1) own = 1;
      else if (r2) own = 2;
      bits.delete();
      wcnt = 0;
    end else begin
      r = (own == 1) ? r1 : r2;
      v = (own == 1) ? v1 : v2;
      a = (own == 1) ? a1 : a2;
      if (conn) begin
        if (d || !r) mdl_release();
        else begin
          wcnt++;
          if (wcnt >= TO) begin
            e_to = 1;
            mdl_release();
          end
        end
      end else if (!r) begin
        mdl_release();
      end else if (v) begin
        bits.push_back(int'(a));
        wcnt = 0;
        if (bits.size() == 2) begin
          sid = bits[0] * 2 + bits[1];
          if (sid == 0) begin
            e_err = 1;
            mdl_release();
          end else begin
            conn = 1;
          end
        end
      end else begin
        wcnt++;
        if (wcnt >= TO) begin
          e_to = 1;
          mdl_release();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("m1_grant", 4'(bus.m1_grant), 4'(own == 1));
    chk("m2_grant", 4'(bus.m2_grant), 4'(own == 2));
    chk("master_grant", 4'(bus.master_grant),
        4'((own == 2) * 2 + (own == 1)));
    chk("slave_grant", 4'(bus.slave_grant),
        conn ? 4'(sid * 2 + 1) : 4'd0);
    chk("addr_error", 4'(bus.addr_error), 4'(e_err));
    chk("bus_timeout", 4'(bus.bus_timeout), 4'(e_to));
  endtask

  task automatic cyc(input bit r1, r2, v1, v2,
                     input bit a1, a2, d);
    bus.m1_request      = r1;
    bus.m2_request      = r2;
    bus.m1_master_valid = v1;
    bus.m2_master_valid = v2;
    bus.m1_tx_address   = a1;
    bus.m2_tx_address   = a2;
    bus.trans_done      = d;
    @(posedge clk);
    mdl_step(r1, r2, v1, v2, a1, a2, d);
    #1;
    compare_all();
  endtask

  initial begin
    bit r1, r2;
    mdl_reset();
    rstn = 1'b0;
    bus.m1_request      = 1'b1;
    bus.m2_request      = 1'b1;
    bus.m1_master_valid = 1'b0;
    bus.m2_master_valid = 1'b0;
    bus.m1_tx_address   = 1'b0;
    bus.m2_tx_address   = 1'b0;
    bus.trans_done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m1g", 4'(bus.m1_grant), 4'd0);
    chk("rst_m2g", 4'(bus.m2_grant), 4'd0);
    chk("rst_mg", 4'(bus.master_grant), 4'd0);
    chk("rst_sg", 4'(bus.slave_grant), 4'd0);
    chk("rst_err", 4'(bus.addr_error), 4'd0);
    chk("rst_to", 4'(bus.bus_timeout), 4'd0);
    rstn = 1'b1;

    // tie after reset goes to m1
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("first_m1g", 4'(bus.m1_grant), 4'd1);
    chk("first_mg", 4'(bus.master_grant), 4'd1);
    // m1 sends 1,0 -> slave 2
    cyc(1, 1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("sg_101", 4'(bus.slave_grant), 4'b0101);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    chk("done_sg", 4'(bus.slave_grant), 4'd0);
    chk("done_m1g", 4'(bus.m1_grant), 4'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("gap_mg", 4'(bus.master_grant), 4'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rr_mg", 4'(bus.master_grant), 4'b0010);
    // m2 sends 0,0 -> address error
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    chk("err_pulse", 4'(bus.addr_error), 4'd1);
    chk("err_sg", 4'(bus.slave_grant), 4'd0);
    chk("err_m2g", 4'(bus.m2_grant), 4'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("err_once", 4'(bus.addr_error), 4'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rr_m1", 4'(bus.master_grant), 4'd1);
    // m1 -> slave 3 then stall into timeout
    cyc(1, 1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 0);
    chk("sg_111", 4'(bus.slave_grant), 4'b0111);
    for (int k = 1; k <= TO; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("tmo_at", 4'(bus.bus_timeout),
          4'(k == TO));
    end
    chk("tmo_sg", 4'(bus.slave_grant), 4'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("solo_m1", 4'(bus.m1_grant), 4'd1);
    // abort after one bit
    cyc(1, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("abort_g", 4'(bus.m1_grant), 4'd0);
    chk("abort_err", 4'(bus.addr_error), 4'd0);
    chk("abort_to", 4'(bus.bus_timeout), 4'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // m2 -> slave 1, then async reset mid-connect
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0);
    chk("sg_011", 4'(bus.slave_grant), 4'b0011);
    cyc(0, 1, 0, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sg", 4'(bus.slave_grant), 4'd0);
    chk("arst_mg", 4'(bus.master_grant), 4'd0);
    mdl_reset();
    @(negedge clk);
    rstn = 1'b1;

    // random traffic
    r1 = 0;
    r2 = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) r1 = ~r1;
      if ($urandom_range(0, 11) == 0) r2 = ~r2;
      cyc(r1, r2,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
